// File: rtl/piso_pkg.sv
// Constants shared by the parallel-in/serial-out block and its serial-in/parallel-out
// counterpart: default geometry, chunk order and the handshake FSM states.
package piso_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 8;
  // Most-significant chunk travels first on the serial side.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/chunk_counter.sv
// Remaining-chunk counter: loads DEPTH, decrements per chunk, flags the final chunk.
// Saturates at zero so a stray decrement can never wrap.
module chunk_counter
  import piso_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic one
);
  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (load)               cnt <= CW'(DEPTH);
    else if (dec && cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign one = (cnt == CW'(1));
endmodule

// File: rtl/piso.sv
// Parallel-in/serial-out shifter with valid/ready on both sides. The final-chunk
// handshake reopens the input in the same cycle so words stream with no gap.
module piso
  import piso_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH*WIDTH-1:0] pi,
  input  logic                   pi_dv,
  output logic                   pi_rdy,
  output logic [WIDTH-1:0]       so,
  output logic                   so_dv,
  input  logic                   so_rdy,
  output logic                   so_last
);
  localparam int DW = DEPTH * WIDTH;

  state_t          state, state_nx;
  logic [DW-1:0]   sr;
  logic            cnt_one;
  logic            load, so_fire, final_fire;

  assign so_dv      = (state == SHIFT);
  assign so_last    = so_dv & cnt_one;
  assign so_fire    = so_dv & so_rdy;
  assign final_fire = so_fire & so_last;
  assign pi_rdy     = (state == IDLE) | final_fire;
  assign load       = pi_dv & pi_rdy;
  assign so         = MSB_FIRST ? sr[DW-1 -: WIDTH] : sr[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load)            state_nx = SHIFT;
    else if (final_fire) state_nx = IDLE;
  end

  // Shift only on non-final chunks; the last chunk stays put until reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     sr <= '0;
    else if (load)                sr <= pi;
    else if (so_fire && !so_last) sr <= MSB_FIRST ? (sr << WIDTH) : (sr >> WIDTH);
  end

  chunk_counter #(.DEPTH(DEPTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dec  (so_fire),
    .one  (cnt_one)
  );
endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: DEPTH=4/WIDTH=8 main instance plus a DEPTH=1 instance
// for single-chunk streaming; a behavioural collector rebuilds words for loopback.
module tb_piso;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pi;
  logic        pi_dv, pi_rdy, so_dv, so_rdy, so_last;
  logic [7:0]  so;

  logic [7:0]  pi1, so1;
  logic        pi_dv1, pi_rdy1, so_dv1, so_rdy1, so_last1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso #(.DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pi(pi), .pi_dv(pi_dv), .pi_rdy(pi_rdy),
    .so(so), .so_dv(so_dv), .so_rdy(so_rdy), .so_last(so_last)
  );

  piso #(.DEPTH(1), .WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .pi(pi1), .pi_dv(pi_dv1), .pi_rdy(pi_rdy1),
    .so(so1), .so_dv(so_dv1), .so_rdy(so_rdy1), .so_last(so_last1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  exp4 [4];
    logic [7:0]  exp8 [8];
    logic [31:0] q [$];
    logic [31:0] acc, word, got;
    int          sent, recv, nchunk, cyc;

    rst = 1'b0; pi = '0; pi_dv = 1'b0; so_rdy = 1'b0;
    pi1 = '0; pi_dv1 = 1'b0; so_rdy1 = 1'b0;
    #2;
    chk("rst_so_dv",   so_dv,   1'b0);
    chk("rst_so",      so,      8'h00);
    chk("rst_so_last", so_last, 1'b0);
    chk("rst_pi_rdy",  pi_rdy,  1'b1);
    step(); step();
    rst = 1'b1;

    // Single word, no backpressure
    exp4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    pi = 32'hA1B2C3D4; pi_dv = 1'b1; so_rdy = 1'b1;
    #1 chk("w1_pi_rdy_idle", pi_rdy, 1'b1);
    step();
    pi_dv = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("w1_so",      so,      exp4[i]);
      chk("w1_so_dv",   so_dv,   1'b1);
      chk("w1_so_last", so_last, (i == 3));
      chk("w1_pi_rdy",  pi_rdy,  (i == 3));
      step();
    end
    chk("w1_end_so_dv", so_dv, 1'b0);
    chk("w1_end_pi_rdy", pi_rdy, 1'b1);

    // Backpressure on B2; pi_dv during the stall must be ignored
    pi = 32'hA1B2C3D4; pi_dv = 1'b1; so_rdy = 1'b1;
    step();
    pi_dv = 1'b0;
    #1 chk("bp_a1", so, 8'hA1);
    step();
    so_rdy = 1'b0; pi = 32'hDEADBEEF; pi_dv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin so_rdy = 1'b1; pi_dv = 1'b0; end
      #1;
      chk("bp_hold_so",    so,     8'hB2);
      chk("bp_hold_so_dv", so_dv,  1'b1);
      chk("bp_hold_pi_rdy", pi_rdy, 1'b0);
      step();
    end
    chk("bp_c3", so, 8'hC3);
    step();
    chk("bp_d4", so, 8'hD4);
    chk("bp_d4_last", so_last, 1'b1);
    step();
    chk("bp_end_so_dv", so_dv, 1'b0);

    // Back-to-back words with pi_dv held high
    exp8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pi = 32'h11223344; pi_dv = 1'b1; so_rdy = 1'b1;
    step();
    pi = 32'h55667788;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) pi_dv = 1'b0;
      #1;
      chk("b2b_so",      so,      exp8[i]);
      chk("b2b_so_dv",   so_dv,   1'b1);
      chk("b2b_so_last", so_last, (i == 3 || i == 7));
      step();
    end
    chk("b2b_end_so_dv", so_dv, 1'b0);

    // Asynchronous reset while B2 is presented
    pi = 32'hA1B2C3D4; pi_dv = 1'b1; so_rdy = 1'b1;
    step();
    pi_dv = 1'b0;
    step();
    chk("ar_pre_b2", so, 8'hB2);
    #2 rst = 1'b0;
    #1;
    chk("ar_so_dv",   so_dv,   1'b0);
    chk("ar_so",      so,      8'h00);
    chk("ar_so_last", so_last, 1'b0);
    step();
    rst = 1'b1;
    #1 chk("ar_pi_rdy", pi_rdy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ar_no_tail", so_dv, 1'b0);
    end

    // Loopback: random words, random so_rdy, rebuild MSB-first
    sent = 0; recv = 0; nchunk = 0; acc = '0; cyc = 0;
    word = $urandom;
    while (recv < 1000 && cyc < 20000) begin
      so_rdy = ($urandom_range(3) != 0);
      pi_dv  = (sent < 1000);
      pi     = word;
      #1;
      if (pi_dv && pi_rdy) begin
        q.push_back(word);
        sent++;
        word = $urandom;
      end
      if (so_dv && so_rdy) begin
        chk("lb_last", so_last, (nchunk == 3));
        acc = {acc[23:0], so};
        nchunk++;
        if (nchunk == 4) begin
          got = (q.size() != 0) ? q.pop_front() : 32'hxxxxxxxx;
          chk("lb_word", acc, got);
          nchunk = 0;
          recv++;
        end
      end
      step();
      cyc++;
    end
    pi_dv = 1'b0;
    chk("lb_recv_count", recv, 1000);

    // DEPTH=1: one word per cycle, each chunk final
    pi1 = 8'h00; pi_dv1 = 1'b1; so_rdy1 = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      pi1 = 8'(k + 1);
      if (k == 15) pi_dv1 = 1'b0;
      #1;
      chk("d1_so",      so1,      8'(k));
      chk("d1_so_dv",   so_dv1,   1'b1);
      chk("d1_so_last", so_last1, 1'b1);
      chk("d1_pi_rdy",  pi_rdy1,  1'b1);
      step();
    end
    chk("d1_end_so_dv", so_dv1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 Parameter DEPTH, default 8, number of chunks per parallel word (DEPTH >= 1).
REQ-002 Parameter WIDTH, default 8, bits per serial chunk (WIDTH >= 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 pi  input  DEPTH*WIDTH  parallel word to serialize.
REQ-006 pi_dv  input  1  pi valid; word is accepted in a cycle where pi_dv and pi_rdy are both 1.
REQ-007 pi_rdy  output  1  block can accept a new parallel word this cycle.
REQ-008 so  output  WIDTH  current serial chunk.
REQ-009 so_dv  output  1  so valid.
REQ-010 so_rdy  input  1  downstream accepts so in a cycle where so_dv and so_rdy are both 1.
REQ-011 so_last  output  1  so is the final chunk of the current word; qualified by so_dv.

Function
REQ-012 Two states: IDLE (no word held) and SHIFT (word held, chunks pending).
REQ-013 IDLE: pi_rdy = 1, so_dv = 0; a pi handshake loads pi into the shift register, loads the remaining-chunk counter with DEPTH, and moves to SHIFT.
REQ-014 Latency: word accepted at edge N -> so_dv = 1 with the first chunk on so from edge N through at least edge N+1.
REQ-015 Chunk order: most-significant chunk first (pi[DEPTH*WIDTH-1 -: WIDTH]), least-significant last, so a serial-in/parallel-out shifter with equal parameters reconstructs pi exactly.
REQ-016 SHIFT: so_dv = 1 continuously; so, so_last and the internal word stay stable while so_rdy = 0 (backpressure holds indefinitely).
REQ-017 SHIFT, so handshake on a non-final chunk: shift the register one chunk toward MSB, decrement the counter, present the next chunk the following cycle.
REQ-018 so_last = 1 exactly when the counter equals 1.
REQ-019 Handshake on the final chunk with pi_dv = 0 -> return to IDLE; so_dv = 0 the next cycle.
REQ-020 pi_rdy = 1 in SHIFT only during a cycle with a final-chunk handshake (so_dv & so_rdy & so_last), combinationally from so_rdy; a pi handshake in that cycle loads the new word and stays in SHIFT, giving zero idle cycles between words.
REQ-021 pi and pi_dv are ignored whenever pi_rdy = 0; no word is queued or dropped silently beyond that.
REQ-022 Counter width $clog2(DEPTH+1); never underflows, never exceeds DEPTH.
REQ-023 DEPTH = 1: every chunk has so_last = 1; back-to-back words stream one per cycle under continuous so_rdy.

Reset
REQ-024 rst = 0 asynchronously forces IDLE, counter = 0, shift register = 0, so = 0, so_dv = 0, so_last = 0; pi_rdy = 1 after release.
REQ-025 Reset mid-word discards all remaining chunks; no partial word is emitted after release.
REQ-026 Reset release is sampled synchronously; first pi handshake can occur in the first cycle after release.

Structure
REQ-027 The chunk-order rule (MSB first) and default DEPTH/WIDTH are shared constants in the project header, common to this block and the matching serial-in/parallel-out block.
REQ-028 The remaining-chunk counter is a sub-module chunk_counter (load, decrement, count==1 flag), parameterized by DEPTH, reusable by the receive side.
REQ-029 No other sub-modules; state register, shift register and handshake logic live in piso.

Verification (bench DEPTH=4, WIDTH=8)
REQ-030 pi = 0xA1B2C3D4, pi_dv one cycle, so_rdy = 1 -> so = A1,B2,C3,D4 on consecutive cycles, so_last only on D4, so_dv low next cycle.
REQ-031 Same word, so_rdy = 0 for 5 cycles on chunk B2 -> so holds B2 with so_dv = 1 for 6 cycles, pi_rdy = 0 throughout, then C3, D4.
REQ-032 pi_dv held high with 0x11223344 then 0x55667788, so_rdy = 1 -> 8 contiguous chunks 11..88, no gap, so_last on 44 and 88.
REQ-033 rst = 0 asynchronously while so = B2 -> so_dv, so, so_last = 0 immediately; after release pi_rdy = 1 and no C3/D4 ever appears.
REQ-034 Loopback into serial-in/parallel-out block (DEPTH=4, WIDTH=8), 1000 random words with random so_rdy gaps -> every reconstructed word equals the sent word.
REQ-035 DEPTH=1 build, pi_dv and so_rdy held high, pi incrementing 0x00..0x0F -> so = 0x00..0x0F one per cycle, so_last = 1 on each.
